fast_bconv_ex_stream: RTL and testbench

- Parametrised, streaming successor of the B∪Ba→q exact fast base conversion (BEHZ fastBConvEx) used in the RNS multiply/relinearise path.
- Accepts LANES coefficients per beat and emits exact residues in an arbitrary output basis through a 4-stage stallable pipeline.
- Uses ready/valid handshaking on both sides and marks frame boundaries, so a polynomial of N_SLOTS coefficients streams in N_SLOTS/LANES beats.
- The Ba residue is carried through the pipeline with its coefficient. Gamma only advances with the pipeline, which removes the unlatched-input and glitching-gamma problems of the previous block.

---
 rtl/fhe_bconv_pkg.sv | 43 ++++
 rtl/bconv_ex_lane.sv | 108 ++++++++++
 rtl/fast_bconv_ex_stream.sv | 83 ++++++++
 tb/tb_fast_bconv_ex_stream.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fhe_bconv_pkg.sv
// ============================================================================
// Module      : fhe_bconv_pkg
// Description : Basis constants, lookup tables and residue types for the
//               B u Ba -> q exact fast base conversion pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fhe_bconv_pkg;

  localparam int PRIME_BITS = 30;
  localparam int B_LEN      = 2;
  localparam int OUT_LEN    = 2;
  localparam int PIPE_DEPTH = 4;

  typedef logic [PRIME_BITS-1:0]        rns_residue_t;
  typedef logic signed [PRIME_BITS:0]   signed_residue_t;

  // B = {7, 11} (B = 77), Ba = 13, q = {5, 17}
  localparam rns_residue_t B_BASIS   [B_LEN]   = '{rns_residue_t'(7), rns_residue_t'(11)};
  localparam rns_residue_t BA_PRIME            = rns_residue_t'(13);
  localparam rns_residue_t OUT_BASIS [OUT_LEN] = '{rns_residue_t'(5), rns_residue_t'(17)};

  localparam rns_residue_t Z_LUT [B_LEN] = '{rns_residue_t'(2), rns_residue_t'(8)};
  localparam rns_residue_t Y_B_TO_OUT [B_LEN][OUT_LEN] = '{
    '{rns_residue_t'(1), rns_residue_t'(11)},
    '{rns_residue_t'(2), rns_residue_t'(7)}
  };
  localparam rns_residue_t Y_B_TO_BA [B_LEN]   = '{rns_residue_t'(11), rns_residue_t'(7)};
  localparam rns_residue_t BINV_MOD_BA         = rns_residue_t'(12);
  localparam rns_residue_t B_MOD_OUT [OUT_LEN] = '{rns_residue_t'(2), rns_residue_t'(9)};

  function automatic rns_residue_t mul_mod(input rns_residue_t a,
                                           input rns_residue_t b,
                                           input rns_residue_t m);
    logic [2*PRIME_BITS-1:0] p;
    p = {{PRIME_BITS{1'b0}}, a} * {{PRIME_BITS{1'b0}}, b};
    return rns_residue_t'(p % {{PRIME_BITS{1'b0}}, m});
  endfunction

endpackage

`default_nettype wire

// File: rtl/bconv_ex_lane.sv
// ============================================================================
// Module      : bconv_ex_lane
// Description : Four-stage fastBConvEx datapath for a single coefficient.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bconv_ex_lane
  import fhe_bconv_pkg::*;
(
  input  logic                          clk,
  input  logic                          i_en,
  input  logic [B_LEN*PRIME_BITS-1:0]   i_xb,
  input  logic [PRIME_BITS-1:0]         i_xba,
  output logic [OUT_LEN*PRIME_BITS-1:0] o_res
);

  localparam int SUM_W  = 2*PRIME_BITS + $clog2(B_LEN);
  localparam int DIFF_W = 2*PRIME_BITS + 2;

  rns_residue_t              w_t     [B_LEN];
  rns_residue_t              r_t     [B_LEN];
  rns_residue_t              r_xba1;
  rns_residue_t              r_xba2;
  logic [SUM_W-1:0]          w_sum_q [OUT_LEN];
  logic [SUM_W-1:0]          w_sum_a;
  rns_residue_t              w_sq    [OUT_LEN];
  rns_residue_t              r_sq2   [OUT_LEN];
  rns_residue_t              r_sq3   [OUT_LEN];
  rns_residue_t              w_sa;
  rns_residue_t              r_sa;
  rns_residue_t              w_d;
  rns_residue_t              w_g;
  signed_residue_t           w_gamma;
  signed_residue_t           r_gamma;
  logic signed [DIFF_W-1:0]  w_diff  [OUT_LEN];
  logic signed [DIFF_W-1:0]  w_rem   [OUT_LEN];
  rns_residue_t              w_out   [OUT_LEN];
  rns_residue_t              r_out   [OUT_LEN];

  always_comb begin
    for (int i = 0; i < B_LEN; i++) begin
      w_t[i] = mul_mod(i_xb[i*PRIME_BITS +: PRIME_BITS], Z_LUT[i], B_BASIS[i]);
    end
  end

  always_comb begin
    w_sum_a = '0;
    for (int i = 0; i < B_LEN; i++) begin
      w_sum_a = w_sum_a + SUM_W'(mul_mod(r_t[i], Y_B_TO_BA[i], BA_PRIME));
    end
    w_sa = rns_residue_t'(w_sum_a % SUM_W'(BA_PRIME));
    for (int j = 0; j < OUT_LEN; j++) begin
      w_sum_q[j] = '0;
      for (int i = 0; i < B_LEN; i++) begin
        w_sum_q[j] = w_sum_q[j] + SUM_W'(mul_mod(r_t[i], Y_B_TO_OUT[i][j], OUT_BASIS[j]));
      end
      w_sq[j] = rns_residue_t'(w_sum_q[j] % SUM_W'(OUT_BASIS[j]));
    end
  end

  // Both operands are below m_a, so the PRIME_BITS-wide wrap is exact.
  always_comb begin
    w_d = r_sa - r_xba2;
    if (r_sa < r_xba2) begin
      w_d = r_sa + BA_PRIME - r_xba2;
    end
    w_g = mul_mod(w_d, BINV_MOD_BA, BA_PRIME);
    if (w_g > (BA_PRIME >> 1)) begin
      w_gamma = $signed({1'b0, w_g}) - $signed({1'b0, BA_PRIME});
    end else begin
      w_gamma = $signed({1'b0, w_g});
    end
  end

  always_comb begin
    for (int j = 0; j < OUT_LEN; j++) begin
      w_diff[j] = $signed({{(DIFF_W-PRIME_BITS){1'b0}}, r_sq3[j]})
                - $signed({{(DIFF_W-PRIME_BITS-1){r_gamma[PRIME_BITS]}}, r_gamma})
                * $signed({{(DIFF_W-PRIME_BITS){1'b0}}, B_MOD_OUT[j]});
      w_rem[j]  = w_diff[j] % $signed({{(DIFF_W-PRIME_BITS){1'b0}}, OUT_BASIS[j]});
      if (w_rem[j][DIFF_W-1]) begin
        w_rem[j] = w_rem[j] + $signed({{(DIFF_W-PRIME_BITS){1'b0}}, OUT_BASIS[j]});
      end
      w_out[j]  = rns_residue_t'(w_rem[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_t     <= w_t;
      r_xba1  <= i_xba;
      r_sq2   <= w_sq;
      r_sa    <= w_sa;
      r_xba2  <= r_xba1;
      r_sq3   <= r_sq2;
      r_gamma <= w_gamma;
      r_out   <= w_out;
    end
  end

  for (genvar j = 0; j < OUT_LEN; j++) begin : g_pack
    assign o_res[j*PRIME_BITS +: PRIME_BITS] = r_out[j];
  end

endmodule

`default_nettype wire

// File: rtl/fast_bconv_ex_stream.sv
// ============================================================================
// Module      : fast_bconv_ex_stream
// Description : Streaming multi-lane exact fast base conversion with
//               ready/valid handshake and frame-boundary tagging.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fast_bconv_ex_stream #(
  parameter int PRIME_BITS = 30,
  parameter int N_SLOTS    = 8,
  parameter int LANES      = 2,
  parameter int B_LEN      = 2,
  parameter int OUT_LEN    = 2
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LANES*B_LEN*PRIME_BITS-1:0]   in_xB,
  input  logic [LANES*PRIME_BITS-1:0]         in_xBa,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LANES*OUT_LEN*PRIME_BITS-1:0] out_res,
  output logic                                out_last,
  output logic                                busy
);

  import fhe_bconv_pkg::*;

  localparam int              BEATS    = N_SLOTS / LANES;
  localparam int              CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAG = CNT_W'(BEATS - 1);

  logic                  w_adv;
  logic                  w_accept;
  logic [PIPE_DEPTH-1:0] r_valid;
  logic [CNT_W-1:0]      r_tag [PIPE_DEPTH];
  logic [CNT_W-1:0]      r_cnt;

  // One global advance keeps the lane data, valid bits and tags in lockstep.
  assign w_adv    = !r_valid[PIPE_DEPTH-1] || out_ready;
  assign w_accept = in_valid && w_adv;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      r_cnt   <= '0;
      for (int s = 0; s < PIPE_DEPTH; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_cnt <= (r_cnt == LAST_TAG) ? '0 : r_cnt + 1'b1;
      end
      if (w_adv) begin
        r_valid  <= {r_valid[PIPE_DEPTH-2:0], in_valid};
        r_tag[0] <= r_cnt;
        for (int s = 1; s < PIPE_DEPTH; s++) begin
          r_tag[s] <= r_tag[s-1];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bconv_ex_lane u_lane (
      .clk   (clk),
      .i_en  (w_adv),
      .i_xb  (in_xB[l*B_LEN*PRIME_BITS +: B_LEN*PRIME_BITS]),
      .i_xba (in_xBa[l*PRIME_BITS +: PRIME_BITS]),
      .o_res (out_res[l*OUT_LEN*PRIME_BITS +: OUT_LEN*PRIME_BITS])
    );
  end

  assign in_ready  = w_adv;
  assign out_valid = r_valid[PIPE_DEPTH-1];
  assign out_last  = r_valid[PIPE_DEPTH-1] && (r_tag[PIPE_DEPTH-1] == LAST_TAG);
  assign busy      = |r_valid;

endmodule

`default_nettype wire

// File: tb/tb_fast_bconv_ex_stream.sv
// ============================================================================
// Module      : tb_fast_bconv_ex_stream
// Description : Scoreboard bench for fast_bconv_ex_stream; expected outputs
//               are x mod q_j computed from the integer each beat encodes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fast_bconv_ex_stream;

  localparam int PB    = 30;
  localparam int LANES = 2;
  localparam int BL    = 2;
  localparam int OL    = 2;
  localparam int NSLOT = 8;
  localparam int BEATS = NSLOT / LANES;
  localparam int XW    = LANES*BL*PB;
  localparam int AW    = LANES*PB;
  localparam int RW    = LANES*OL*PB;

  int unsigned b_pr [BL] = '{7, 11};
  int unsigned q_pr [OL] = '{5, 17};
  int unsigned m_a       = 13;

  typedef struct {
    logic [RW-1:0] res;
    logic          last;
  } exp_t;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] in_xB;
  logic [AW-1:0] in_xBa;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_res;
  logic          out_last;
  logic          busy;

  exp_t exp_q [$];
  int   checks     = 0;
  int   errors     = 0;
  int   beat_cnt   = 0;
  int   ready_mode = 0;

  fast_bconv_ex_stream dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_xB     (in_xB),
    .in_xBa    (in_xBa),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, expv);
    end
  endtask

  // Downstream readiness: 0 = always ready, 1 = stalled, 2 = random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send_beat(input int unsigned x0, input int unsigned x1, input bit chk_ready);
    int unsigned xs [LANES];
    exp_t        e;
    int          waited;
    xs[0] = x0;
    xs[1] = x1;
    for (int l = 0; l < LANES; l++) begin
      for (int i = 0; i < BL; i++) begin
        in_xB[(l*BL+i)*PB +: PB] = PB'(xs[l] % b_pr[i]);
      end
      in_xBa[l*PB +: PB] = PB'(xs[l] % m_a);
      for (int j = 0; j < OL; j++) begin
        e.res[(l*OL+j)*PB +: PB] = PB'(xs[l] % q_pr[j]);
      end
    end
    e.last   = (beat_cnt == BEATS-1);
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    if (chk_ready) chk("in_ready_high", in_ready, 1);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready=0 want 1");
    end else begin
      exp_q.push_back(e);
      beat_cnt = (beat_cnt + 1) % BEATS;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", busy, 0);
    chk("drain_queue", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    beat_cnt = 0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin : mon
    logic          held;
    logic [RW-1:0] hres;
    logic          hlast;
    exp_t          e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          checks++;
          if (!out_valid || out_res !== hres || out_last !== hlast) begin
            errors++;
            $display("FAIL hold_stable got v=%0b res=%h last=%0b want v=1 res=%h last=%0b",
                     out_valid, out_res, out_last, hres, hlast);
          end
        end
        held = 1'b0;
        if (out_valid && !out_ready) begin
          held  = 1'b1;
          hres  = out_res;
          hlast = out_last;
        end else if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat got res=%h want none", out_res);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (out_res !== e.res) begin
              errors++;
              $display("FAIL out_res got %h want %h", out_res, e.res);
            end
            checks++;
            if (out_last !== e.last) begin
              errors++;
              $display("FAIL out_last got %0b want %0b", out_last, e.last);
            end
          end
        end
      end
    end
  end

  initial begin
    int lat;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_xB    = '0;
    in_xBa   = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat with latency measurement, then boundary values
    send_beat(20, 0, 1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    chk("latency", lat, 4);
    @(posedge clk);
    #1;
    send_beat(76, 38, 1);
    drain();

    // Full frame back-to-back from a fresh counter
    do_reset();
    for (int k = 0; k < BEATS; k++) begin
      send_beat(2*k, 2*k+1, 1);
    end
    drain();

    // Backpressure while feeding two frames
    @(posedge clk);
    #1;
    fork
      begin
        for (int k = 0; k < 8; k++) send_beat($urandom_range(0, 76), $urandom_range(0, 76), 0);
      end
      begin
        ready_mode = 1;
        repeat (5) @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid_high", out_valid, 1);
        ready_mode = 0;
      end
    join
    drain();

    // Reset with three beats in flight
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) send_beat($urandom_range(0, 76), $urandom_range(0, 76), 1);
    #1;
    chk("pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    exp_q.delete();
    beat_cnt = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(20, 0, 1);
    drain();

    // Randomised traffic with random ready toggling
    @(posedge clk);
    #1;
    ready_mode = 2;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat($urandom_range(0, 76), $urandom_range(0, 76), 0);
    end
    ready_mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
